seg7_scanner: RTL and testbench
===============================

# seg7_scanner

Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display. It sits directly downstream of the clock divider and consumes its scan strobe as a single-cycle enable on the system clock. It shows a 16-bit hex value with per-digit decimal points and per-digit enables. Every digit change inserts a blanking gap, which suppresses ghosting.

## Interface
- BLANK_CYCLES, default 16: `clk` cycles with all anodes off after each digit change; range 0..255.
- clk  input  1  system clock (50 MHz); all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_tick  input  1  one-`clk`-cycle scan strobe from the clock divider; advances to the next digit.
- i_value  input  16  hex value; digit k shows i_value[4k+3:4k]; digit 0 is rightmost.
- i_dp  input  4  decimal point per digit, 1 = lit.
- i_digit_en  input  4  digit enable, 1 = shown; 0 = anode kept off.
- o_an  output  4  anodes, active-low; o_an[k] drives digit k.
- o_seg  output  7  segments, active-low; o_seg[0]=a through o_seg[6]=g.
- o_dp  output  1  decimal point, active-low.
- o_digit  output  2  index of the current digit.
- o_frame  output  1  one-cycle pulse on wrap from digit 3 to digit 0.

## Operation
- State machine has two states: BLANK and SHOW.
- Reset (rst_n low at an edge):
  - state = BLANK, digit = 0, blank counter = 0.
  - o_an = 4'b1111, o_seg = 7'b1111111, o_dp = 1, o_digit = 0, o_frame = 0.
  - Snapshot registers are cleared to 0.
- Snapshot:
  - i_value, i_dp and i_digit_en are captured into internal registers on the first edge in BLANK for digit 0.
  - This happens after reset release and after every wrap.
  - Digits 1..3 always display the snapshot taken for the same frame, so a frame never tears.
- BLANK:
  - o_an = 4'b1111.
  - The counter increments each cycle.
  - When counter == BLANK_CYCLES-1, next state is SHOW and the counter clears.
  - i_tick is ignored in BLANK; no queuing.
- SHOW:
  - o_an[digit] = ~snap_en[digit]; all other anodes are 1.
  - o_seg = hex decode of the snapshot nibble.
  - o_dp = ~snap_dp[digit].
  - On i_tick: digit = digit+1 mod 4, state = BLANK.
  - On the 3->0 step, o_frame = 1 for exactly that one cycle.
- BLANK_CYCLES = 0: BLANK is skipped. A tick in SHOW moves directly to SHOW of the next digit on the following edge, and the snapshot is still taken on the wrap.
- Hex decode (o_seg as binary, bit 6..0 = g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- During BLANK, o_seg and o_dp hold the next digit's pattern. Only the anodes gate visibility.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- After rst_n goes high, o_an[0] goes low (if enabled) on the BLANK_CYCLES-th rising edge with rst_n high. With BLANK_CYCLES=0, this is the first such edge.
- A tick seen at edge N in SHOW makes all anodes high from edge N. The next anode goes low at edge N+BLANK_CYCLES (N+1 when BLANK_CYCLES=0).
- o_frame is asserted for the single cycle following the edge that samples the wrapping tick.
- Back-to-back ticks: only a tick sampled in SHOW advances the digit. With BLANK_CYCLES ≥ 1, consecutive ticks cannot skip a digit.
- Reset mid-scan:
  - Applies on the next edge regardless of state or counter.
  - Outputs return to their reset values.
  - The scan restarts at digit 0 with a fresh snapshot.

## Test plan
- Reset and first display: BLANK_CYCLES=4, i_value=16'h1234, all enabled, rst_n low then high -> o_an=1111 for 4 edges; o_an becomes 1110, o_seg=0011001 ("4") at edge 4; o_digit=0.
- Full scan: with the above, issue 4 ticks spaced 20 cycles apart -> digits show 4,3,2,1 on anodes 1110,1101,1011,0111; each change is preceded by 4 cycles of 1111; o_frame pulses once, on the 4th tick.
- Snapshot atomicity: change i_value to 16'hABCD while digit 1 is shown -> digits 2 and 3 still show 2 and 1; the next frame shows D,C,b,A.
- Enables and dp: i_digit_en=4'b0101, i_dp=4'b0001 -> o_an stays 1111 during SHOW of digits 1 and 3; o_dp=0 only on digit 0.
- Ticks in BLANK and zero blank: a tick on every cycle with BLANK_CYCLES=4 -> the digit advances only once per 5 cycles; with BLANK_CYCLES=0, the anode moves to the next digit one edge after each tick with no all-off cycle.
- Mid-scan reset: assert rst_n low for 1 cycle while digit 2 is in SHOW -> o_an=1111, o_digit=0, o_seg=1111111 next cycle, then the startup sequence repeats.

Source files
------------

// File: rtl/seg7_scanner.sv
// seg7_scanner: 4-digit common-anode 7-seg scan driver with blanking gap.
// Ports: clk, rst_n, i_tick, i_value/i_dp/i_digit_en in; o_an/o_seg/o_dp/o_digit/o_frame out.
module seg7_scanner #(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_digit_en,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [1:0]  o_digit,
  output logic        o_frame
);

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  localparam bit NO_BLANK = (BLANK_CYCLES == 0);
  localparam logic [7:0] LAST =
    NO_BLANK ? 8'd0 : 8'(BLANK_CYCLES - 1);

  logic [0:0]  state, state_n;
  logic [1:0]  digit, digit_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] snap_val, snap_val_n;
  logic [3:0]  snap_dp, snap_dp_n;
  logic [3:0]  snap_en, snap_en_n;

  logic        capture;
  logic        advance;
  logic        wrap;
  logic        hold;
  logic [3:0]  nib;
  logic [3:0]  onehot;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7f;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      4'hf: s = 7'b0001110;
      default: s = 7'h7f;
    endcase
    return s;
  endfunction

  // First BLANK edge of digit 0 opens a new frame.
  assign capture = (state == BLANK) && (digit == 2'd0)
                && (cnt == 8'd0);
  assign advance = (state == SHOW) && i_tick;
  assign wrap    = advance && (digit == 2'd3);
  // Without a gap the lit digit stays up for the
  // transient BLANK cycle instead of going dark.
  assign hold    = NO_BLANK && advance;

  always_comb begin
    snap_val_n = capture ? i_value    : snap_val;
    snap_dp_n  = capture ? i_dp       : snap_dp;
    snap_en_n  = capture ? i_digit_en : snap_en;
    state_n    = state;
    digit_n    = digit;
    cnt_n      = cnt;
    unique case (state)
      BLANK: begin
        if (NO_BLANK || cnt == LAST) begin
          state_n = SHOW;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      SHOW: begin
        if (i_tick) begin
          digit_n = digit + 2'd1;
          state_n = BLANK;
        end
      end
      default: state_n = BLANK;
    endcase
  end

  // Outputs are precomputed from next-state values
  // so they are registered yet current.
  always_comb begin
    nib    = snap_val_n[{digit_n, 2'b00} +: 4];
    seg_n  = hex7(nib);
    dp_n   = ~snap_dp_n[digit_n];
    onehot = 4'b0001 << digit_n;
    an_n   = 4'b1111;
    if (state_n == SHOW)
      an_n = ~(onehot & snap_en_n);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BLANK;
      digit    <= 2'd0;
      cnt      <= 8'd0;
      snap_val <= 16'h0;
      snap_dp  <= 4'h0;
      snap_en  <= 4'h0;
      o_an     <= 4'b1111;
      o_seg    <= 7'b1111111;
      o_dp     <= 1'b1;
      o_digit  <= 2'd0;
      o_frame  <= 1'b0;
    end else begin
      state    <= state_n;
      digit    <= digit_n;
      cnt      <= cnt_n;
      snap_val <= snap_val_n;
      snap_dp  <= snap_dp_n;
      snap_en  <= snap_en_n;
      o_digit  <= digit_n;
      o_frame  <= wrap;
      if (!hold) begin
        o_an  <= an_n;
        o_seg <= seg_n;
        o_dp  <= dp_n;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: scoreboard bench for seg7_scanner.
// Two instances: 4-cycle blanking gap and zero gap.
module tb_seg7_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;

  logic        clk = 1'b0;
  logic        rst_n, rst0_n;
  logic        tick, tick0;
  logic [15:0] value;
  logic [3:0]  dp, en;

  logic [3:0] an4, an0;
  logic [6:0] seg4, seg0;
  logic       dp4, dp0, fr4, fr0;
  logic [1:0] dig4, dig0;

  seg7_scanner #(.BLANK_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .i_tick(tick),
    .i_value(value), .i_dp(dp), .i_digit_en(en),
    .o_an(an4), .o_seg(seg4), .o_dp(dp4),
    .o_digit(dig4), .o_frame(fr4)
  );

  seg7_scanner #(.BLANK_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst0_n), .i_tick(tick0),
    .i_value(value), .i_dp(dp), .i_digit_en(en),
    .o_an(an0), .o_seg(seg0), .o_dp(dp0),
    .o_digit(dig0), .o_frame(fr0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          dut0;
    string       name;
    logic [14:0] exp;
    logic [14:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [14:0] M_ALL  = 15'h7fff;
  localparam logic [14:0] M_NSEG = 15'b1111_0000000_0_11_1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [14:0] got;
      e = q.pop_front();
      got = e.dut0 ? {an0, seg0, dp0, dig0, fr0}
                   : {an4, seg4, dp4, dig4, fr4};
      n_vec++;
      if ((got & e.mask) !== (e.exp & e.mask)) begin
        n_bad++;
        $display("FAIL %s: an/seg/dp/dig/fr got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
          e.name, got[14:11], got[10:4], got[3], got[2:1], got[0],
          e.exp[14:11], e.exp[10:4], e.exp[3], e.exp[2:1], e.exp[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input bit d0,
    input logic [3:0] a, input logic [6:0] s, input logic p,
    input logic [1:0] g, input logic f, input bit chk_seg);
    exp_t e;
    e.cyc  = cyc;
    e.dut0 = d0;
    e.name = nm;
    e.exp  = {a, s, p, g, f};
    e.mask = chk_seg ? M_ALL : M_NSEG;
    q.push_back(e);
  endtask

  // One tick into the 4-gap unit, check gap and next digit.
  task automatic tick4(input string nm, input logic [1:0] g,
    input logic [3:0] a, input logic [6:0] s, input logic p,
    input logic f);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    expect_o({nm, "_gap0"}, 0, 4'hf, 7'h0, 1'b0, g, f, 0);
    step(3);
    expect_o({nm, "_gap3"}, 0, 4'hf, 7'h0, 1'b0, g, 1'b0, 0);
    step(1);
    expect_o({nm, "_show"}, 0, a, s, p, g, 1'b0, 1);
    step(15);
  endtask

  // One tick into the zero-gap unit.
  task automatic tick0_do(input string nm, input logic [1:0] g,
    input logic [3:0] pa, input logic [6:0] ps,
    input logic [3:0] a, input logic [6:0] s, input logic f);
    tick0 = 1'b1;
    step(1);
    tick0 = 1'b0;
    expect_o({nm, "_hold"}, 1, pa, ps, 1'b1, g, f, 1);
    step(1);
    expect_o({nm, "_show"}, 1, a, s, 1'b1, g, 1'b0, 1);
    step(3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    rst0_n = 1'b0;
    tick   = 1'b0;
    tick0  = 1'b0;
    value  = 16'h1234;
    dp     = 4'h0;
    en     = 4'hf;
    step(2);
    expect_o("reset", 0, 4'hf, 7'h7f, 1'b1, 2'd0, 1'b0, 1);
    expect_o("reset0", 1, 4'hf, 7'h7f, 1'b1, 2'd0, 1'b0, 1);
    rst_n = 1'b1;
    step(3);
    expect_o("start_gap", 0, 4'hf, 7'h0, 1'b0, 2'd0, 1'b0, 0);
    step(1);
    expect_o("start_show", 0, 4'he, S4, 1'b1, 2'd0, 1'b0, 1);
    step(16);

    tick4("d1", 2'd1, 4'hd, S3, 1'b1, 1'b0);
    value = 16'habcd;
    tick4("d2", 2'd2, 4'hb, S2, 1'b1, 1'b0);
    tick4("d3", 2'd3, 4'h7, S1, 1'b1, 1'b0);
    tick4("n0", 2'd0, 4'he, SD, 1'b1, 1'b1);
    tick4("n1", 2'd1, 4'hd, SC, 1'b1, 1'b0);
    tick4("n2", 2'd2, 4'hb, SB, 1'b1, 1'b0);
    tick4("n3", 2'd3, 4'h7, SA, 1'b1, 1'b0);

    en = 4'b0101;
    dp = 4'b0001;
    tick4("e0", 2'd0, 4'he, SD, 1'b0, 1'b1);
    tick4("e1", 2'd1, 4'hf, SC, 1'b1, 1'b0);
    tick4("e2", 2'd2, 4'hb, SB, 1'b1, 1'b0);
    tick4("e3", 2'd3, 4'hf, SA, 1'b1, 1'b0);
    tick4("e4", 2'd0, 4'he, SD, 1'b0, 1'b1);

    tick = 1'b1;
    step(1);
    expect_o("bb_adv1", 0, 4'hf, 7'h0, 1'b0, 2'd1, 1'b0, 0);
    step(4);
    expect_o("bb_wait", 0, 4'hf, SC, 1'b1, 2'd1, 1'b0, 1);
    step(1);
    expect_o("bb_adv2", 0, 4'hf, 7'h0, 1'b0, 2'd2, 1'b0, 0);
    tick = 1'b0;
    step(4);
    expect_o("bb_show2", 0, 4'hb, SB, 1'b1, 2'd2, 1'b0, 1);
    step(2);

    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_o("midrst", 0, 4'hf, 7'h7f, 1'b1, 2'd0, 1'b0, 1);
    step(3);
    expect_o("re_gap", 0, 4'hf, 7'h0, 1'b0, 2'd0, 1'b0, 0);
    step(1);
    expect_o("re_show", 0, 4'he, SD, 1'b0, 2'd0, 1'b0, 1);

    value  = 16'h1234;
    en     = 4'hf;
    dp     = 4'h0;
    rst0_n = 1'b1;
    step(1);
    expect_o("z_start", 1, 4'he, S4, 1'b1, 2'd0, 1'b0, 1);
    step(3);
    tick0_do("z1", 2'd1, 4'he, S4, 4'hd, S3, 1'b0);
    tick0_do("z2", 2'd2, 4'hd, S3, 4'hb, S2, 1'b0);
    value = 16'habcd;
    tick0_do("z3", 2'd3, 4'hb, S2, 4'h7, S1, 1'b0);
    tick0_do("z0", 2'd0, 4'h7, S1, 4'he, SD, 1'b1);
    tick0_do("z1b", 2'd1, 4'he, SD, 4'hd, SC, 1'b0);

    step(3);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries unchecked, want 0",
        q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
